// File: rtl/acc_bank_pkg.sv
// acc_bank_pkg: shared encodings and sizing helpers for the accumulator bank.
// Exports the saturate-mode encoding and the channel-index width function.
package acc_bank_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } sat_mode_e;

    // Channel-index width; never below 1 so a single-bit port is always legal.
    function automatic int ch_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/acc_bank_add.sv
// acc_bank_add: shared ACC_W-bit adder with carry-out and saturate mux.
// Ports: acc/data operands, sat select in; sum and carry out.
module acc_bank_add
    import acc_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    input  logic              sat,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + (ACC_W+1)'(data);
    assign carry = wide[ACC_W];

    // Saturate only clamps when the add actually overflowed.
    assign sum = (carry && (sat == SAT)) ? '1 : wide[ACC_W-1:0];

endmodule

// File: rtl/acc_bank.sv
// acc_bank: NCH-channel accumulator bank, 2-stage pipeline, one update/cycle.
// Ports: clk/reset, in_* command, sat_mode, out_* result, rd_ch/rd_* read port.
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int NCH    = 4,
    localparam int CH_W  = ch_width(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_load,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              sat_mode,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_ovf
);

    localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

    // Stage 1: unconditional capture of the command.
    logic              valid1;
    logic              load1;
    logic [CH_W-1:0]   ch1;
    logic [DATA_W-1:0] data1;
    logic              sat1;

    // Channel state held in flops.
    logic [ACC_W-1:0]  acc [NCH];
    logic              ovf [NCH];

    logic              ch_ok;
    logic              upd;
    logic [ACC_W-1:0]  cur_acc;
    logic              cur_ovf;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic [ACC_W-1:0]  new_acc;
    logic              new_ovf;
    logic              rd_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1 <= 1'b0;
            load1  <= 1'b0;
            ch1    <= '0;
            data1  <= '0;
            sat1   <= 1'b0;
        end else begin
            valid1 <= in_valid;
            load1  <= in_load;
            ch1    <= in_ch;
            data1  <= in_data;
            sat1   <= sat_mode;
        end
    end

    // Out-of-range channels (non power-of-two NCH) turn into no-ops.
    assign ch_ok   = ({1'b0, ch1} < NCH_V);
    assign upd     = valid1 && ch_ok;
    assign cur_acc = ch_ok ? acc[ch1] : '0;
    assign cur_ovf = ch_ok ? ovf[ch1] : 1'b0;

    acc_bank_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc   (cur_acc),
        .data  (data1),
        .sat   (sat1),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        new_acc = add_sum;
        new_ovf = cur_ovf | add_carry;
        if (load1) begin
            new_acc = ACC_W'(data1);
            new_ovf = 1'b0;
        end
    end

    // Reading acc here gives the result of the previous edge, so
    // back-to-back updates to one channel chain without a bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (upd && (ch1 == CH_W'(i))) begin
                    acc[i] <= new_acc;
                    ovf[i] <= new_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= upd;
            if (upd) begin
                out_ch   <= ch1;
                out_data <= new_acc;
                out_ovf  <= new_ovf;
            end
        end
    end

    assign rd_ok   = ({1'b0, rd_ch} < NCH_V);
    assign rd_data = rd_ok ? acc[rd_ch] : '0;
    assign rd_ovf  = rd_ok ? ovf[rd_ch] : 1'b0;

endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed scoreboard bench for acc_bank.
// Three instances: default, 8-bit accumulator, and NCH=3.
module tb_acc_bank;
    import acc_bank_pkg::*;

    typedef struct {
        logic [1:0]  ch;
        logic [39:0] data;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q8[$];
    exp_t q3[$];

    // default instance
    logic        u0_in_valid, u0_in_load, u0_sat;
    logic [1:0]  u0_in_ch, u0_out_ch, u0_rd_ch;
    logic [31:0] u0_in_data;
    logic        u0_out_valid, u0_out_ovf, u0_rd_ovf;
    logic [39:0] u0_out_data, u0_rd_data;

    // 8-bit instance
    logic        u8_in_valid, u8_in_load, u8_sat;
    logic [1:0]  u8_in_ch, u8_out_ch, u8_rd_ch;
    logic [7:0]  u8_in_data;
    logic        u8_out_valid, u8_out_ovf, u8_rd_ovf;
    logic [7:0]  u8_out_data, u8_rd_data;

    // three-channel instance
    logic        u3_in_valid, u3_in_load, u3_sat;
    logic [1:0]  u3_in_ch, u3_out_ch, u3_rd_ch;
    logic [31:0] u3_in_data;
    logic        u3_out_valid, u3_out_ovf, u3_rd_ovf;
    logic [39:0] u3_out_data, u3_rd_data;

    acc_bank u0 (
        .clk(clk), .reset(reset),
        .in_valid(u0_in_valid), .in_load(u0_in_load),
        .in_ch(u0_in_ch), .in_data(u0_in_data), .sat_mode(u0_sat),
        .out_valid(u0_out_valid), .out_ch(u0_out_ch),
        .out_data(u0_out_data), .out_ovf(u0_out_ovf),
        .rd_ch(u0_rd_ch), .rd_data(u0_rd_data), .rd_ovf(u0_rd_ovf)
    );

    acc_bank #(.DATA_W(8), .ACC_W(8), .NCH(4)) u8 (
        .clk(clk), .reset(reset),
        .in_valid(u8_in_valid), .in_load(u8_in_load),
        .in_ch(u8_in_ch), .in_data(u8_in_data), .sat_mode(u8_sat),
        .out_valid(u8_out_valid), .out_ch(u8_out_ch),
        .out_data(u8_out_data), .out_ovf(u8_out_ovf),
        .rd_ch(u8_rd_ch), .rd_data(u8_rd_data), .rd_ovf(u8_rd_ovf)
    );

    acc_bank #(.DATA_W(32), .ACC_W(40), .NCH(3)) u3 (
        .clk(clk), .reset(reset),
        .in_valid(u3_in_valid), .in_load(u3_in_load),
        .in_ch(u3_in_ch), .in_data(u3_in_data), .sat_mode(u3_sat),
        .out_valid(u3_out_valid), .out_ch(u3_out_ch),
        .out_data(u3_out_data), .out_ovf(u3_out_ovf),
        .rd_ch(u3_rd_ch), .rd_data(u3_rd_data), .rd_ovf(u3_rd_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [39:0] obs,
                         input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (u0_out_valid !== 1'b0) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_out", 40'(u0_out_valid), 40'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_out_ch", 40'(u0_out_ch), 40'(e.ch));
                check("u0_out_data", u0_out_data, e.data);
                check("u0_out_ovf", 40'(u0_out_ovf), 40'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (u8_out_valid !== 1'b0) begin
            if (q8.size() == 0) begin
                check("u8_unexpected_out", 40'(u8_out_valid), 40'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("u8_out_ch", 40'(u8_out_ch), 40'(e.ch));
                check("u8_out_data", 40'(u8_out_data), e.data);
                check("u8_out_ovf", 40'(u8_out_ovf), 40'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (u3_out_valid !== 1'b0) begin
            if (q3.size() == 0) begin
                check("u3_unexpected_out", 40'(u3_out_valid), 40'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("u3_out_ch", 40'(u3_out_ch), 40'(e.ch));
                check("u3_out_data", u3_out_data, e.data);
                check("u3_out_ovf", 40'(u3_out_ovf), 40'(e.ovf));
            end
        end
    end

    task automatic idle(input int n);
        u0_in_valid = 1'b0;
        u8_in_valid = 1'b0;
        u3_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic ld, input logic [1:0] ch,
                         input logic [31:0] d, input logic s,
                         input logic [39:0] ed, input logic eo,
                         input bit push);
        u0_in_valid = 1'b1;
        u0_in_load  = ld;
        u0_in_ch    = ch;
        u0_in_data  = d;
        u0_sat      = s;
        if (push) q0.push_back('{ch, ed, eo});
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic ld, input logic [1:0] ch,
                         input logic [7:0] d, input logic s,
                         input logic [39:0] ed, input logic eo);
        u8_in_valid = 1'b1;
        u8_in_load  = ld;
        u8_in_ch    = ch;
        u8_in_data  = d;
        u8_sat      = s;
        q8.push_back('{ch, ed, eo});
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic ld, input logic [1:0] ch,
                         input logic [31:0] d, input logic s,
                         input logic [39:0] ed, input logic eo,
                         input bit push);
        u3_in_valid = 1'b1;
        u3_in_load  = ld;
        u3_in_ch    = ch;
        u3_in_data  = d;
        u3_sat      = s;
        if (push) q3.push_back('{ch, ed, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] c;
        reset = 1'b1;
        u0_in_valid = 0; u0_in_load = 0; u0_in_ch = 0;
        u0_in_data = 0;  u0_sat = 0;     u0_rd_ch = 0;
        u8_in_valid = 0; u8_in_load = 0; u8_in_ch = 0;
        u8_in_data = 0;  u8_sat = 0;     u8_rd_ch = 0;
        u3_in_valid = 0; u3_in_load = 0; u3_in_ch = 0;
        u3_in_data = 0;  u3_sat = 0;     u3_rd_ch = 0;

        #2;
        check("rst_out_valid", 40'(u0_out_valid), 40'd0);
        check("rst_out_data", u0_out_data, 40'd0);
        check("rst_out_ovf", 40'(u0_out_ovf), 40'd0);
        check("rst_u8_out_data", 40'(u8_out_data), 40'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // chained adds on ch2, 2-cycle latency
        send0(0, 2'd2, 32'd5, WRAP, 40'd5, 0, 1);
        check("lat_stage1_only", 40'(u0_out_valid), 40'd0);
        send0(0, 2'd2, 32'd7, WRAP, 40'd12, 0, 1);
        check("lat_first_valid", 40'(u0_out_valid), 40'd1);
        check("lat_first_data", u0_out_data, 40'd5);
        send0(0, 2'd2, 32'd9, WRAP, 40'd21, 0, 1);
        idle(3);
        check("hold_out_data", u0_out_data, 40'd21);
        for (int i = 0; i < 4; i++) begin
            u0_rd_ch = 2'(i);
            #1;
            check("rd_after_ch2", u0_rd_data, (i == 2) ? 40'd21 : 40'd0);
        end

        // interleaved ch0/ch1, read of in-flight channel sees pre-edge value
        for (int i = 0; i < 8; i++) begin
            c = 2'(i % 2);
            send0(0, c, 32'd1, WRAP, 40'(i / 2 + 1), 0, 1);
            u0_rd_ch = c;
            #1;
            check("rd_pre_edge", u0_rd_data, 40'(i / 2));
        end
        idle(3);
        u0_rd_ch = 2'd0;
        #1;
        check("interleave_ch0", u0_rd_data, 40'd4);
        u0_rd_ch = 2'd1;
        #1;
        check("interleave_ch1", u0_rd_data, 40'd4);

        // asynchronous reset with both stages busy
        send0(0, 2'd1, 32'd100, WRAP, 40'd0, 0, 0);
        send0(0, 2'd3, 32'd200, WRAP, 40'd0, 0, 0);
        check("busy_before_reset", 40'(u0_out_valid), 40'd1);
        u0_in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", 40'(u0_out_valid), 40'd0);
        check("async_out_ch", 40'(u0_out_ch), 40'd0);
        check("async_out_data", u0_out_data, 40'd0);
        check("async_out_ovf", 40'(u0_out_ovf), 40'd0);
        for (int i = 0; i < 4; i++) begin
            u0_rd_ch = 2'(i);
            #1;
            check("async_rd_data", u0_rd_data, 40'd0);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send0(0, 2'd3, 32'd6, WRAP, 40'd6, 0, 1);
        idle(3);
        u0_rd_ch = 2'd3;
        #1;
        check("post_reset_ch3", u0_rd_data, 40'd6);
        u0_rd_ch = 2'd1;
        #1;
        check("post_reset_ch1", u0_rd_data, 40'd0);

        // 8-bit wrap and saturate
        send8(1, 2'd0, 8'd250, WRAP, 40'd250, 0);
        send8(0, 2'd0, 8'd10, WRAP, 40'd4, 1);
        send8(0, 2'd0, 8'd1, WRAP, 40'd5, 1);
        send8(1, 2'd1, 8'd250, SAT, 40'd250, 0);
        send8(0, 2'd1, 8'd10, SAT, 40'd255, 1);
        send8(0, 2'd1, 8'd1, SAT, 40'd255, 1);
        send8(1, 2'd1, 8'd3, SAT, 40'd3, 0);
        idle(3);
        u8_rd_ch = 2'd0;
        #1;
        check("u8_rd_ch0", 40'(u8_rd_data), 40'd5);
        check("u8_rd_ovf0", 40'(u8_rd_ovf), 40'd1);
        u8_rd_ch = 2'd1;
        #1;
        check("u8_rd_ch1", 40'(u8_rd_data), 40'd3);
        check("u8_rd_ovf1", 40'(u8_rd_ovf), 40'd0);

        // NCH=3: channel 3 is a no-op
        send3(0, 2'd0, 32'd7, WRAP, 40'd7, 0, 1);
        send3(0, 2'd3, 32'd9, WRAP, 40'd0, 0, 0);
        idle(1);
        check("nch3_no_valid", 40'(u3_out_valid), 40'd0);
        check("nch3_hold_data", u3_out_data, 40'd7);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            u3_rd_ch = 2'(i);
            #1;
            check("nch3_rd_data", u3_rd_data, (i == 0) ? 40'd7 : 40'd0);
            check("nch3_rd_ovf", 40'(u3_rd_ovf), 40'd0);
        end

        idle(2);
        check("q0_drained", 40'(q0.size()), 40'd0);
        check("q8_drained", 40'(q8.size()), 40'd0);
        check("q3_drained", 40'(q3.size()), 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
